// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   - key code constants for the operator and special keys
//   - KEYMAP: code for each key, indexed by row*4 + col
//   - frame classification and debounce state encodings
package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'h0;
    localparam logic [3:0] KEY_ADD  = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'hB;
    localparam logic [3:0] KEY_MUL  = 4'hC;
    localparam logic [3:0] KEY_DIV  = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Element [row*4 + col]; listed from index 15 (r3,c3) down to 0 (r0,c0).
    localparam logic [15:0][3:0] KEYMAP = {
        KEY_DIV, KEY_HASH, 4'h0, KEY_STAR,  // r3: c3..c0
        KEY_MUL, 4'h9,     4'h8, 4'h7,      // r2
        KEY_SUB, 4'h6,     4'h5, 4'h4,      // r1
        KEY_ADD, 4'h3,     4'h2, 4'h1       // r0
    };

    typedef enum logic [1:0] {
        FRAME_NONE  = 2'd0,
        FRAME_KEY   = 2'd1,
        FRAME_MULTI = 2'd2
    } frame_cls_t;

    typedef enum logic {
        DB_IDLE = 1'b0,
        DB_HELD = 1'b1
    } db_state_t;

endpackage

// File: rtl/keypad_scan_decoder_debounce.sv
// keypad_debounce: compares each classified frame against a candidate,
// counts consecutive matches and commits presses, roll-overs and releases.
// Optional feature macro: KEYPAD_REPEAT_EN (repeat strobes while held).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   frame_vld           one-cycle pulse at the end of each full scan
//   frame_cls/code      classification and key code of that scan
//   decode, key_valid   committed key code and key-held flag (registered)
//   key_strobe          one-cycle pulse per commit (and per repeat)
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_vld,
    input  frame_cls_t frame_cls,
    input  logic [3:0] frame_code,
    output logic [3:0] decode,
    output logic       key_valid,
    output logic       key_strobe
);

    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_SCANS);

    db_state_t    state;
    frame_cls_t   cand_cls;
    logic [3:0]   cand_code;
    logic [MW-1:0] match_cnt;

    logic          same;
    logic [MW-1:0] next_cnt;
    logic          reached;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_cnt;
`endif

    // Non-KEY frames always carry code 0, so a plain compare covers all classes.
    always_comb begin
        same = (frame_cls == cand_cls) && (frame_code == cand_code);
        if (frame_cls == FRAME_MULTI)
            next_cnt = '0;
        else if (same)
            next_cnt = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + MW'(1);
        else
            next_cnt = MW'(1);
        reached = (next_cnt == MATCH_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DB_IDLE;
            cand_cls   <= FRAME_NONE;
            cand_code  <= KEY_NONE;
            match_cnt  <= '0;
            decode     <= KEY_NONE;
            key_valid  <= 1'b0;
            key_strobe <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt    <= '0;
`endif
        end else begin
            key_strobe <= 1'b0;
            if (frame_vld) begin
                cand_cls  <= frame_cls;
                cand_code <= frame_code;
                match_cnt <= next_cnt;
                case (state)
                    DB_IDLE: begin
                        if (frame_cls == FRAME_KEY && reached) begin
                            state      <= DB_HELD;
                            decode     <= frame_code;
                            key_valid  <= 1'b1;
                            key_strobe <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt    <= '0;
`endif
                        end
                    end
                    DB_HELD: begin
                        if (frame_cls == FRAME_KEY && reached && frame_code != decode) begin
                            decode     <= frame_code;
                            key_strobe <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt    <= '0;
`endif
                        end else if (frame_cls == FRAME_NONE && reached) begin
                            state     <= DB_IDLE;
                            decode    <= KEY_NONE;
                            key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt   <= '0;
`endif
                        end
`ifdef KEYPAD_REPEAT_EN
                        // Any frame that is not the held key restarts the repeat interval.
                        else if (frame_cls == FRAME_KEY && frame_code == decode) begin
                            if (rep_cnt == RW'(REPEAT_SCANS - 1)) begin
                                rep_cnt    <= '0;
                                key_strobe <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + RW'(1);
                            end
                        end else begin
                            rep_cnt <= '0;
                        end
`endif
                    end
                    default: state <= DB_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder: scans a 4x4 active-low matrix keypad and produces a
// debounced 4-bit key code for the game FSM.
// Optional feature macro: KEYPAD_REPEAT_EN (periodic strobes while a key is held).
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   row[3:0]    keypad rows, active-low with external pull-ups
//   col[3:0]    column drive, active-low, exactly one bit low
//   decode[3:0] debounced key code, 4'h0 when idle
//   key_valid   high while a committed key is held
//   key_strobe  one-cycle pulse on each committed press
module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] decode,
    output logic       key_valid,
    output logic       key_strobe
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [15:0]   acc;        // one bit per key, index row*4 + col
    logic [15:0]   acc_next;
    logic          last_dwell;
    logic          frame_vld;
    frame_cls_t    frame_cls;
    logic [3:0]    frame_code;
    logic [4:0]    hits;
    logic [3:0]    hit_code;

    assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
    assign frame_vld  = last_dwell && (col_idx == 2'd3);
    assign col        = ~(4'b0001 << col_idx);

    // Merge the rows seen under the current column into the frame image.
    always_comb begin
        acc_next = acc;
        if (last_dwell) begin
            for (int r = 0; r < 4; r++)
                acc_next[r*4 + int'(col_idx)] = acc[r*4 + int'(col_idx)] | ~row[r];
        end
    end

    // Classification uses acc_next so the column-3 sample of this cycle counts.
    always_comb begin
        hits     = '0;
        hit_code = KEY_NONE;
        for (int i = 0; i < 16; i++) begin
            if (acc_next[i]) begin
                hits     = hits + 5'd1;
                hit_code = KEYMAP[i];
            end
        end
        frame_code = KEY_NONE;
        if (hits == 5'd0) begin
            frame_cls = FRAME_NONE;
        end else if (hits == 5'd1) begin
            frame_cls  = FRAME_KEY;
            frame_code = hit_code;
        end else begin
            frame_cls = FRAME_MULTI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= 2'd0;
            acc     <= '0;
        end else if (last_dwell) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            acc     <= (col_idx == 2'd3) ? 16'h0000 : acc_next;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .REPEAT_SCANS  (REPEAT_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .frame_vld (frame_vld),
        .frame_cls (frame_cls),
        .frame_code(frame_code),
        .decode    (decode),
        .key_valid (key_valid),
        .key_strobe(key_strobe)
    );

endmodule

// File: tb/tb_keypad_scan_decoder.sv
module tb_keypad_scan_decoder;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int RS       = 5;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] decode;
    logic       key_valid;
    logic       key_strobe;
    logic [15:0] keys;   // pressed keys, index row*4 + col

    always #5 clk = ~clk;

    keypad_scan_decoder #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_SCANS  (RS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .decode    (decode),
        .key_valid (key_valid),
        .key_strobe(key_strobe)
    );

    // Keypad model: a pressed key shorts its row to its column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && !col[c]) row[r] = 1'b0;
    end

    typedef struct packed {
        logic [3:0] dec;
        logic       vld;
        logic       stb;
    } ev_t;

    ev_t exp_q[$];
    int  applied = 0;
    int  miscompares = 0;
    int  popped = 0;
    bit  mon_en = 1'b0;
    logic [3:0] prev_dec = 4'h0;
    logic       prev_vld = 1'b0;

    function automatic ev_t mk(input logic [3:0] d, input logic v, input logic s);
        ev_t e;
        e.dec = d;
        e.vld = v;
        e.stb = s;
        return e;
    endfunction

    // Monitor: every output change or strobe is one event, checked against the queue.
    always @(negedge clk) begin
        ev_t got;
        ev_t want;
        if (mon_en && (decode !== prev_dec || key_valid !== prev_vld || key_strobe !== 1'b0)) begin
            got = mk(decode, key_valid, key_strobe);
            applied++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got dec=%h vld=%b stb=%b, required no event",
                         got.dec, got.vld, got.stb);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL event_%0d: got dec=%h vld=%b stb=%b, required dec=%h vld=%b stb=%b",
                             popped, got.dec, got.vld, got.stb, want.dec, want.vld, want.stb);
                end
            end
            popped++;
        end
        prev_dec = decode;
        prev_vld = key_valid;
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        applied++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic wait_pop(input int target, input int budget, input string name);
        int n = 0;
        while (popped < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        applied++;
        if (popped < target) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d events, required %0d within %0d cycles",
                     name, popped, target, budget);
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        keys = 16'h0000;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_decode", {4'h0, decode}, 8'h00);
        check("rst_valid",  {7'h0, key_valid}, 8'h00);
        check("rst_strobe", {7'h0, key_strobe}, 8'h00);
        check("rst_col",    {4'h0, col}, 8'h0E);
        rst = 1'b0;
        prev_dec = decode;
        prev_vld = key_valid;
        mon_en = 1'b1;

        // Column scan: one column low, advancing every SCAN_DIV cycles.
        for (int k = 1; k <= 4; k++) begin
            repeat (SCAN_DIV) @(negedge clk);
            check($sformatf("scan_col_%0d", k), {4'h0, col}, {4'h0, ~(4'b0001 << (k % 4))});
        end
        repeat (4) @(negedge clk);

        // 1: steady '2' (r0,c1)
        tgt = popped + 1;
        exp_q.push_back(mk(4'h2, 1'b1, 1'b1));
        keys = 16'h0002;
        wait_pop(tgt, 64, "t1_press");
        check("t1_valid", {7'h0, key_valid}, 8'h01);
        tgt = popped + 1;
        exp_q.push_back(mk(4'h0, 1'b0, 1'b0));
        keys = 16'h0000;
        wait_pop(tgt, 5 * FRAME, "t1_release");

        // 2: bouncing '2' never commits
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0002 : 16'h0000;
            repeat (5) @(negedge clk);
        end
        keys = 16'h0000;
        repeat (6 * FRAME) @(negedge clk);
        check("t2_decode", {4'h0, decode}, 8'h00);
        check("t2_valid",  {7'h0, key_valid}, 8'h00);

        // 3: 'A' (r0,c3), release, 'A' again
        tgt = popped + 1;
        exp_q.push_back(mk(4'hA, 1'b1, 1'b1));
        keys = 16'h0008;
        wait_pop(tgt, 5 * FRAME, "t3_press1");
        tgt = popped + 1;
        exp_q.push_back(mk(4'h0, 1'b0, 1'b0));
        keys = 16'h0000;
        wait_pop(tgt, 4 * FRAME, "t3_release");
        tgt = popped + 1;
        exp_q.push_back(mk(4'hA, 1'b1, 1'b1));
        keys = 16'h0008;
        wait_pop(tgt, 5 * FRAME, "t3_press2");
        tgt = popped + 1;
        exp_q.push_back(mk(4'h0, 1'b0, 1'b0));
        keys = 16'h0000;
        wait_pop(tgt, 5 * FRAME, "t3_release2");

        // 4: '1'+'4' from idle, then '3'+'6' while '3' is held
        keys = 16'h0011;
        repeat (10 * FRAME) @(negedge clk);
        check("t4_idle_decode", {4'h0, decode}, 8'h00);
        check("t4_idle_valid",  {7'h0, key_valid}, 8'h00);
        keys = 16'h0000;
        repeat (5 * FRAME) @(negedge clk);
        tgt = popped + 1;
        exp_q.push_back(mk(4'h3, 1'b1, 1'b1));
        keys = 16'h0004;
        wait_pop(tgt, 5 * FRAME, "t4_press3");
        keys = 16'h0044;
        repeat (10 * FRAME) @(negedge clk);
        check("t4_held_decode", {4'h0, decode}, 8'h03);
        check("t4_held_valid",  {7'h0, key_valid}, 8'h01);
        tgt = popped + 1;
        exp_q.push_back(mk(4'h0, 1'b0, 1'b0));
        keys = 16'h0000;
        wait_pop(tgt, 5 * FRAME, "t4_release");

        // 5: roll-over 'B' (r1,c3) -> 'C' (r2,c3)
        tgt = popped + 1;
        exp_q.push_back(mk(4'hB, 1'b1, 1'b1));
        keys = 16'h0080;
        wait_pop(tgt, 5 * FRAME, "t5_pressB");
        tgt = popped + 1;
        exp_q.push_back(mk(4'hC, 1'b1, 1'b1));
        keys = 16'h0800;
        wait_pop(tgt, 5 * FRAME, "t5_rollC");
        check("t5_valid", {7'h0, key_valid}, 8'h01);
        tgt = popped + 1;
        exp_q.push_back(mk(4'h0, 1'b0, 1'b0));
        keys = 16'h0000;
        wait_pop(tgt, 5 * FRAME, "t5_release");

        // 6: reset while 'D' (r3,c3) is held
        tgt = popped + 1;
        exp_q.push_back(mk(4'hD, 1'b1, 1'b1));
        keys = 16'h8000;
        wait_pop(tgt, 5 * FRAME, "t6_press");
        repeat (7) @(negedge clk);
        tgt = popped + 1;
        exp_q.push_back(mk(4'h0, 1'b0, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_decode", {4'h0, decode}, 8'h00);
        check("t6_rst_valid",  {7'h0, key_valid}, 8'h00);
        check("t6_rst_col",    {4'h0, col}, 8'h0E);
        rst = 1'b0;
        wait_pop(tgt, 2, "t6_rst_event");
        tgt = popped + 1;
        exp_q.push_back(mk(4'hD, 1'b1, 1'b1));
        wait_pop(tgt, 5 * FRAME, "t6_recommit");
        tgt = popped + 1;
        exp_q.push_back(mk(4'h0, 1'b0, 1'b0));
        keys = 16'h0000;
        wait_pop(tgt, 5 * FRAME, "t6_release");

`ifdef KEYPAD_REPEAT_EN
        // Repeat: '5' (r1,c1) held; strobes at +5, +10, +15 frames after commit.
        tgt = popped + 1;
        exp_q.push_back(mk(4'h5, 1'b1, 1'b1));
        keys = 16'h0020;
        wait_pop(tgt, 5 * FRAME, "rep_commit");
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(4'h5, 1'b1, 1'b1));
        repeat (17 * FRAME + 8) @(negedge clk);
        check("rep_count", 8'(popped - tgt), 8'd3);
        tgt = popped + 1;
        exp_q.push_back(mk(4'h0, 1'b0, 1'b0));
        keys = 16'h0000;
        wait_pop(tgt, 5 * FRAME, "rep_release");
`endif

        repeat (2 * FRAME) @(negedge clk);
        check("queue_empty", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
